// File: rtl/rv32i_multicycle_control.sv
// rv32i_multicycle_control: main control FSM sequencing the shared multicycle datapath.
// Define ILLEGAL_TRAP_EN to trap undecodable opcodes in a sticky ILLEGAL state.
module rv32i_multicycle_control (
    input  logic       clk,
    input  logic       rst,
    input  logic [6:0] op,
    input  logic [2:0] funct3,
    input  logic       zero,
    input  logic       memReady,
    output logic       pcWrite,
    output logic       adrSrc,
    output logic       memWrite,
    output logic       irWrite,
    output logic [1:0] resultSrc,
    output logic [1:0] aluSrcA,
    output logic [1:0] aluSrcB,
    output logic [1:0] aluOp,
    output logic       regWrite,
    output logic [1:0] inmSrc,
    output logic       illegal
);

    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_BR  = 7'b1100011;
    localparam logic [6:0] OP_JAL = 7'b1101111;

    typedef enum logic [3:0] {
        FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE,
        EXECR, EXECI, ALUWB, BRANCH, JAL
`ifdef ILLEGAL_TRAP_EN
        , ILLEGAL
`endif
    } state_t;

    typedef struct packed {
        logic       fetch;
        logic       pc_update;
        logic       branch;
        logic       adr_src;
        logic       mem_write;
        logic       reg_write;
        logic       illegal;
        logic [1:0] result_src;
        logic [1:0] alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic [1:0] inm_src;
    } ctrl_t;

    localparam ctrl_t FETCH_CTRL = '{
        fetch: 1'b1, alu_src_b: 2'b10, result_src: 2'b10, default: '0
    };

    state_t state;
    state_t state_nxt;
    ctrl_t  ctrl;
    logic   unused_bits;

    function automatic ctrl_t ctrl_for(input state_t s, input logic [6:0] opc);
        ctrl_t c;
        c = '0;
        case (s)
            FETCH: begin
                c.fetch      = 1'b1;
                c.alu_src_b  = 2'b10;
                c.result_src = 2'b10;
            end
            DECODE: begin
                c.alu_src_a = 2'b01;
                c.alu_src_b = 2'b01;
                c.inm_src   = 2'b10;
            end
            MEMADR: begin
                c.alu_src_a = 2'b10;
                c.alu_src_b = 2'b01;
                c.inm_src   = (opc == OP_SW) ? 2'b01 : 2'b00;
            end
            MEMREAD: c.adr_src = 1'b1;
            MEMWB: begin
                c.result_src = 2'b01;
                c.reg_write  = 1'b1;
            end
            MEMWRITE: begin
                c.adr_src   = 1'b1;
                c.mem_write = 1'b1;
            end
            EXECR: begin
                c.alu_src_a = 2'b10;
                c.alu_op    = 2'b10;
            end
            EXECI: begin
                c.alu_src_a = 2'b10;
                c.alu_src_b = 2'b01;
                c.alu_op    = 2'b10;
            end
            ALUWB: c.reg_write = 1'b1;
            BRANCH: begin
                c.alu_src_a = 2'b10;
                c.alu_op    = 2'b01;
                c.inm_src   = 2'b10;
                c.branch    = 1'b1;
            end
            JAL: begin
                c.alu_src_a = 2'b01;
                c.alu_src_b = 2'b10;
                c.inm_src   = 2'b11;
                c.pc_update = 1'b1;
            end
`ifdef ILLEGAL_TRAP_EN
            ILLEGAL: c.illegal = 1'b1;
`endif
            default: c = '0;
        endcase
        return c;
    endfunction

    function automatic state_t next_of(input state_t s, input logic [6:0] opc,
                                       input logic rdy);
        state_t n;
        n = s;
        case (s)
            FETCH: if (rdy) n = DECODE;
            DECODE: begin
                case (opc)
                    OP_LW, OP_SW: n = MEMADR;
                    OP_R:         n = EXECR;
                    OP_I:         n = EXECI;
                    OP_BR:        n = BRANCH;
                    OP_JAL:       n = JAL;
                    default:
`ifdef ILLEGAL_TRAP_EN
                        n = ILLEGAL;
`else
                        n = FETCH;
`endif
                endcase
            end
            MEMADR:   n = (opc == OP_SW) ? MEMWRITE : MEMREAD;
            MEMREAD:  if (rdy) n = MEMWB;
            MEMWRITE: if (rdy) n = FETCH;
            EXECR, EXECI, JAL: n = ALUWB;
            MEMWB, ALUWB, BRANCH: n = FETCH;
`ifdef ILLEGAL_TRAP_EN
            ILLEGAL: n = ILLEGAL;
`endif
            default: n = FETCH;
        endcase
        return n;
    endfunction

    assign state_nxt = next_of(state, op, memReady);

    // Control word is registered alongside the state so every select is glitch-free.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= FETCH;
            ctrl  <= FETCH_CTRL;
        end else begin
            state <= state_nxt;
            ctrl  <= ctrl_for(state_nxt, op);
        end
    end

    assign irWrite   = ~rst & ctrl.fetch & memReady;
    assign pcWrite   = ~rst & ((ctrl.fetch & memReady) | ctrl.pc_update |
                               (ctrl.branch & (zero ^ funct3[0])));
    assign adrSrc    = ctrl.adr_src;
    assign memWrite  = ctrl.mem_write;
    assign regWrite  = ctrl.reg_write;
    assign resultSrc = ctrl.result_src;
    assign aluSrcA   = ctrl.alu_src_a;
    assign aluSrcB   = ctrl.alu_src_b;
    assign aluOp     = ctrl.alu_op;
    assign inmSrc    = ctrl.inm_src;

`ifdef ILLEGAL_TRAP_EN
    assign illegal     = ctrl.illegal;
    assign unused_bits = ^funct3[2:1];
`else
    assign illegal     = 1'b0;
    assign unused_bits = ^{funct3[2:1], ctrl.illegal};
`endif

endmodule

// File: tb/tb_rv32i_multicycle_control.sv
// tb_rv32i_multicycle_control: scoreboard bench for the multicycle control FSM.
// Expected control vectors come from a behavioural state model kept in the bench.
module tb_rv32i_multicycle_control;

    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_BR  = 7'b1100011;
    localparam logic [6:0] OP_JAL = 7'b1101111;
    localparam logic [6:0] OP_BAD = 7'b1111111;

    // {pcWrite,irWrite,memWrite,regWrite,illegal,adrSrc,resultSrc,aluSrcA,aluSrcB,aluOp,inmSrc}
    localparam logic [15:0] RST_EXP = 16'b00000_0_10_00_10_00_00;

    typedef enum int {
        S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB, S_MEMWRITE,
        S_EXECR, S_EXECI, S_ALUWB, S_BRANCH, S_JAL, S_ILLEGAL
    } mstate_t;

    logic       clk = 1'b0;
    logic       rst;
    logic [6:0] op;
    logic [2:0] funct3;
    logic       zero;
    logic       memReady;
    logic       pcWrite, adrSrc, memWrite, irWrite, regWrite, illegal;
    logic [1:0] resultSrc, aluSrcA, aluSrcB, aluOp, inmSrc;
    logic [15:0] obs;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int last_ir = -1;
    int pend_cpi = 0;
    int cur_fstall = 0;
    string pend_tag = "";
    mstate_t mst = S_FETCH;
    logic [15:0] exp_q[$];

    rv32i_multicycle_control dut (
        .clk(clk), .rst(rst), .op(op), .funct3(funct3), .zero(zero),
        .memReady(memReady), .pcWrite(pcWrite), .adrSrc(adrSrc),
        .memWrite(memWrite), .irWrite(irWrite), .resultSrc(resultSrc),
        .aluSrcA(aluSrcA), .aluSrcB(aluSrcB), .aluOp(aluOp),
        .regWrite(regWrite), .inmSrc(inmSrc), .illegal(illegal)
    );

    assign obs = {pcWrite, irWrite, memWrite, regWrite, illegal, adrSrc,
                  resultSrc, aluSrcA, aluSrcB, aluOp, inmSrc};

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] got,
                         input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] model_out(input mstate_t s, input logic [6:0] o,
                                              input logic f0, input logic z,
                                              input logic rdy);
        logic pw, iw, mw, rw, il, as;
        logic [1:0] rs, sa, sb, ao, is;
        {pw, iw, mw, rw, il, as} = '0;
        {rs, sa, sb, ao, is} = '0;
        case (s)
            S_FETCH:    begin sb = 2'b10; rs = 2'b10; iw = rdy; pw = rdy; end
            S_DECODE:   begin sa = 2'b01; sb = 2'b01; is = 2'b10; end
            S_MEMADR:   begin sa = 2'b10; sb = 2'b01; is = (o == OP_SW) ? 2'b01 : 2'b00; end
            S_MEMREAD:  as = 1'b1;
            S_MEMWB:    begin rs = 2'b01; rw = 1'b1; end
            S_MEMWRITE: begin as = 1'b1; mw = 1'b1; end
            S_EXECR:    begin sa = 2'b10; ao = 2'b10; end
            S_EXECI:    begin sa = 2'b10; sb = 2'b01; ao = 2'b10; end
            S_ALUWB:    rw = 1'b1;
            S_BRANCH:   begin sa = 2'b10; ao = 2'b01; is = 2'b10; pw = z ^ f0; end
            S_JAL:      begin sa = 2'b01; sb = 2'b10; is = 2'b11; pw = 1'b1; end
            S_ILLEGAL:  il = 1'b1;
            default:    ;
        endcase
        return {pw, iw, mw, rw, il, as, rs, sa, sb, ao, is};
    endfunction

    function automatic mstate_t model_next(input mstate_t s, input logic [6:0] o,
                                           input logic rdy);
        case (s)
            S_FETCH:    return rdy ? S_DECODE : S_FETCH;
            S_DECODE: begin
                if (o == OP_LW || o == OP_SW) return S_MEMADR;
                if (o == OP_R)   return S_EXECR;
                if (o == OP_I)   return S_EXECI;
                if (o == OP_BR)  return S_BRANCH;
                if (o == OP_JAL) return S_JAL;
`ifdef ILLEGAL_TRAP_EN
                return S_ILLEGAL;
`else
                return S_FETCH;
`endif
            end
            S_MEMADR:   return (o == OP_SW) ? S_MEMWRITE : S_MEMREAD;
            S_MEMREAD:  return rdy ? S_MEMWB : S_MEMREAD;
            S_MEMWRITE: return rdy ? S_FETCH : S_MEMWRITE;
            S_EXECR, S_EXECI, S_JAL: return S_ALUWB;
            S_ILLEGAL:  return S_ILLEGAL;
            default:    return S_FETCH;
        endcase
    endfunction

    // One clock: push expectation, compare at negedge, advance model, re-align after posedge.
    task automatic step(input string tag);
        exp_q.push_back(model_out(mst, op, funct3[0], zero, memReady));
        @(negedge clk);
        check($sformatf("%s_c%0d", tag, cyc), obs, exp_q.pop_front());
        if (irWrite === 1'b1) begin
            if (last_ir >= 0 && pend_cpi > 0)
                check({pend_tag, "_cpi"}, 16'(cyc - last_ir),
                      16'(pend_cpi + cur_fstall));
            last_ir  = cyc;
            pend_cpi = 0;
        end
        mst = model_next(mst, op, memReady);
        cyc++;
        @(posedge clk);
        #1;
    endtask

    task automatic run_instr(input string tag, input logic [6:0] o, input logic [2:0] f3,
                             input logic z, input int fstall, input int mstall,
                             input int cpi);
        int n;
        op = o; funct3 = f3; zero = z; cur_fstall = fstall;
        for (int i = 0; i < fstall; i++) begin
            memReady = 1'b0;
            step(tag);
        end
        memReady = 1'b1;
        step(tag);
        pend_cpi = cpi;
        pend_tag = tag;
        n = 0;
        while (mst != S_FETCH && mst != S_ILLEGAL && n < 40) begin
            memReady = 1'b1;
            if ((mst == S_MEMREAD || mst == S_MEMWRITE) && mstall > 0) begin
                memReady = 1'b0;
                mstall--;
            end
            step(tag);
            n++;
        end
        if (n >= 40) check({tag, "_timeout"}, 16'(n), 16'd0);
    endtask

    task automatic reset_check(input string tag);
        exp_q.push_back(RST_EXP);
        check(tag, obs, exp_q.pop_front());
    endtask

    task automatic release_reset();
        @(posedge clk);
        #1;
        reset_check("rst_hold");
        rst = 1'b0;
        memReady = 1'b1;
        mst = S_FETCH;
        last_ir = -1;
        pend_cpi = 0;
        cur_fstall = 0;
    endtask

    initial begin
        rst = 1'b1; op = OP_R; funct3 = 3'b000; zero = 1'b0; memReady = 1'b1;
        @(posedge clk);
        #1;
        reset_check("rst_init");
        release_reset();

        run_instr("r",      OP_R,   3'b000, 1'b0, 0, 0, 4);
        run_instr("lw_stl", OP_LW,  3'b010, 1'b0, 0, 2, 7);
        run_instr("sw",     OP_SW,  3'b010, 1'b0, 0, 0, 4);
        run_instr("sw_stl", OP_SW,  3'b010, 1'b1, 0, 1, 5);
        run_instr("i",      OP_I,   3'b000, 1'b1, 0, 0, 4);
        run_instr("beq_t",  OP_BR,  3'b000, 1'b1, 0, 0, 3);
        run_instr("bne_nt", OP_BR,  3'b001, 1'b1, 0, 0, 3);
        run_instr("bne_t",  OP_BR,  3'b001, 1'b0, 0, 0, 3);
        run_instr("beq_nt", OP_BR,  3'b000, 1'b0, 0, 0, 3);
        run_instr("jal",    OP_JAL, 3'b000, 1'b0, 0, 0, 4);
        run_instr("lw_fst", OP_LW,  3'b010, 1'b0, 1, 0, 5);

`ifdef ILLEGAL_TRAP_EN
        run_instr("bad", OP_BAD, 3'b000, 1'b0, 0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            memReady = i[0];
            step("ill_hold");
        end
        rst = 1'b1;
        #1;
        reset_check("rst_ill");
        release_reset();
`else
        run_instr("bad", OP_BAD, 3'b000, 1'b0, 0, 0, 2);
`endif

        // Abandon a load stalled in MEMREAD.
        op = OP_LW; memReady = 1'b1;
        step("rstm");
        step("rstm");
        step("rstm");
        memReady = 1'b0;
        step("rstm");
        rst = 1'b1;
        #1;
        reset_check("rst_mid");
        release_reset();

        run_instr("r2", OP_R, 3'b000, 1'b0, 0, 0, 4);
        op = OP_R; memReady = 1'b1;
        step("tail");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
